id_ex_stage_register: RTL and testbench
=======================================

Name: id_ex_stage_register

Overview:
- Decode-to-execute pipeline register of the 32-bit MIPS core.
- Sits directly downstream of SignExtend and the register file, and upstream of the ALU-source mux.
- Captures decoded operands, the extended immediate and control bits each cycle.
- Detects load-use hazards, inserts bubbles on hazard or branch flush, and holds on external stall.
- Keeps a saturating bubble counter for performance debug.

Parameters:
- DATA_W, 32, operand/immediate width.
- REG_AW, 5, register address width.
- CNT_W, 16, bubble counter width.

Ports:
- clk  in  1  core clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall_in  in  1  global hold (e.g. memory wait); freezes all state.
- flush  in  1  branch/jump taken; the ID instruction becomes a bubble.
- id_valid  in  1  ID stage holds a real instruction.
- id_pc_plus4  in  DATA_W  PC+4 of the ID instruction.
- id_rs_data  in  DATA_W  register file read port A.
- id_rt_data  in  DATA_W  register file read port B.
- id_sign_imm  in  DATA_W  SignExtend output for instr[15:0].
- id_rs_addr, id_rt_addr, id_rd_addr  in  REG_AW each  instruction register fields.
- id_shamt  in  5  shift amount field.
- id_ctrl  in  10  bit map: [0] reg_write, [1] mem_read, [2] mem_write, [3] mem_to_reg, [4] alu_src, [5] reg_dst, [9:6] alu_op.
- id_zero_ext  in  1  logical-immediate op (andi/ori/xori); selects zero extension.
- ex_valid  out  1  EX holds a real instruction.
- ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm  out  DATA_W each  registered operands.
- ex_rs_addr, ex_rt_addr  out  REG_AW each  for forwarding unit.
- ex_write_reg  out  REG_AW  resolved destination register.
- ex_shamt  out  5.
- ex_ctrl  out  10  same bit map as id_ctrl.
- load_use_stall  out  1  combinational; upstream PC and IF/ID must hold.
- bubble_count  out  CNT_W  saturating count of inserted bubbles.

Behaviour:
- Reset (reset=1 at edge): every output register goes to 0, including ex_valid=0, ex_ctrl=0 and bubble_count=0. reset overrides all other inputs. Reset mid-stall clears the state, and the hold no longer applies.
- load_use_stall = ex_valid & ex_ctrl[1] & (ex_rt_addr!=0) & id_valid & (ex_rt_addr==id_rs_addr | ex_rt_addr==id_rt_addr). It is purely combinational from current state and ID inputs, with no added latency.
- Update priority per rising edge: reset > stall_in > flush > load_use_stall > normal load.
  - stall_in=1: all registers hold, including bubble_count. A pending flush is not taken while stall_in=1; the controller keeps flush high until the stall ends.
  - flush=1: bubble loaded. ex_valid=0, ex_ctrl=0, all data/address outputs=0. bubble_count+1.
  - load_use_stall=1 (no flush): same bubble as flush, bubble_count+1. The ID instruction is not consumed; it is re-presented the next cycle by the held IF/ID.
  - Normal: ex_valid<=id_valid; all fields capture ID inputs one cycle later (latency 1).
  - id_valid=0 in a normal load forces ex_ctrl=0.
- Immediate rule: ex_imm = id_zero_ext ? {16'h0000, id_sign_imm[15:0]} : id_sign_imm.
- ex_write_reg = id_ctrl[5] ? id_rd_addr : id_rt_addr, resolved at capture.
- bubble_count saturates at all-ones (16'hFFFF) and never wraps.
- A bubble after a hazard clears ex_ctrl[1], so load_use_stall deasserts the following cycle. A single load-use pair therefore costs exactly one bubble.

Test Plan:
- Reset: hold reset 2 cycles with nonzero inputs -> all outputs 0, bubble_count=0, load_use_stall=0.
- Immediate path:
  - id_sign_imm=32'hFFFF8000, id_zero_ext=0 -> ex_imm=32'hFFFF8000 one cycle later.
  - id_zero_ext=1 -> ex_imm=32'h00008000.
  - id_sign_imm=32'h00002000 -> 32'h00002000 either way.
- Load-use: lw with rt=8 (ex_ctrl[1]=1), next ID add with rs=8 -> load_use_stall=1 that cycle; next edge ex_valid=0, ex_ctrl=0, bubble_count=1. Following cycle load_use_stall=0 and the add captures. Repeat with rt=0 -> no stall.
- Flush vs stall:
  - flush=1 and stall_in=1 together -> state unchanged.
  - stall_in drops with flush still 1 -> bubble, bubble_count increments by 1.
- Destination select: id_ctrl[5]=1, rd=5'd12, rt=5'd3 -> ex_write_reg=12; id_ctrl[5]=0 -> 3.
- Saturation: preload via 65535 flushes -> bubble_count=16'hFFFF; one more flush -> stays 16'hFFFF.

Source files
------------

// File: rtl/id_ex_stage_register_if.sv
// ID-to-EX bus: decoded operands and control from ID, registered copies toward EX.
// The master drives the id_* side and observes ex_*; the slave is the pipeline register.
interface id_ex_stage_register_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5
);
   localparam int unsigned SHAMT_W = 5;
   localparam int unsigned CTRL_W  = 10;

   logic                id_valid;
   logic [DATA_W-1:0]   id_pc_plus4;
   logic [DATA_W-1:0]   id_rs_data;
   logic [DATA_W-1:0]   id_rt_data;
   logic [DATA_W-1:0]   id_sign_imm;
   logic [REG_AW-1:0]   id_rs_addr;
   logic [REG_AW-1:0]   id_rt_addr;
   logic [REG_AW-1:0]   id_rd_addr;
   logic [SHAMT_W-1:0]  id_shamt;
   logic [CTRL_W-1:0]   id_ctrl;
   logic                id_zero_ext;

   logic                ex_valid;
   logic [DATA_W-1:0]   ex_pc_plus4;
   logic [DATA_W-1:0]   ex_rs_data;
   logic [DATA_W-1:0]   ex_rt_data;
   logic [DATA_W-1:0]   ex_imm;
   logic [REG_AW-1:0]   ex_rs_addr;
   logic [REG_AW-1:0]   ex_rt_addr;
   logic [REG_AW-1:0]   ex_write_reg;
   logic [SHAMT_W-1:0]  ex_shamt;
   logic [CTRL_W-1:0]   ex_ctrl;

   modport master (
      output id_valid, id_pc_plus4, id_rs_data, id_rt_data, id_sign_imm,
             id_rs_addr, id_rt_addr, id_rd_addr, id_shamt, id_ctrl, id_zero_ext,
      input  ex_valid, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm,
             ex_rs_addr, ex_rt_addr, ex_write_reg, ex_shamt, ex_ctrl
   );

   modport slave (
      input  id_valid, id_pc_plus4, id_rs_data, id_rt_data, id_sign_imm,
             id_rs_addr, id_rt_addr, id_rd_addr, id_shamt, id_ctrl, id_zero_ext,
      output ex_valid, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm,
             ex_rs_addr, ex_rt_addr, ex_write_reg, ex_shamt, ex_ctrl
   );
endinterface

// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register of the MIPS core: captures decoded operands, detects
// load-use hazards, inserts bubbles on hazard or flush, and counts bubbles.
module id_ex_stage_register #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 stall_in,
   input  logic                 flush,
   id_ex_stage_register_if.slave bus,
   output logic                 load_use_stall,
   output logic [CNT_W-1:0]     bubble_count
);
   localparam int unsigned SHAMT_W      = 5;
   localparam int unsigned CTRL_W       = 10;
   localparam int unsigned IMM_W        = 16;
   localparam int unsigned MEM_READ_BIT = 1;
   localparam int unsigned REG_DST_BIT  = 5;

   logic                bubble;
   logic                rt_hit;
   logic [DATA_W-1:0]   ext_imm;
   logic [REG_AW-1:0]   dest_reg;

   logic                nxt_valid;
   logic [DATA_W-1:0]   nxt_pc_plus4;
   logic [DATA_W-1:0]   nxt_rs_data;
   logic [DATA_W-1:0]   nxt_rt_data;
   logic [DATA_W-1:0]   nxt_imm;
   logic [REG_AW-1:0]   nxt_rs_addr;
   logic [REG_AW-1:0]   nxt_rt_addr;
   logic [REG_AW-1:0]   nxt_write_reg;
   logic [SHAMT_W-1:0]  nxt_shamt;
   logic [CTRL_W-1:0]   nxt_ctrl;
   logic [CNT_W-1:0]    nxt_count;

   // Load in EX whose target is read by the instruction now in ID; $zero never hazards.
   always_comb begin
      rt_hit         = (bus.ex_rt_addr == bus.id_rs_addr) ||
                       (bus.ex_rt_addr == bus.id_rt_addr);
      load_use_stall = bus.ex_valid && bus.ex_ctrl[MEM_READ_BIT] &&
                       (bus.ex_rt_addr != '0) && bus.id_valid && rt_hit;
      bubble         = flush || load_use_stall;
   end

   // Operand shaping resolved at capture time.
   always_comb begin
      ext_imm  = bus.id_zero_ext ? DATA_W'(bus.id_sign_imm[IMM_W-1:0]) : bus.id_sign_imm;
      dest_reg = bus.id_ctrl[REG_DST_BIT] ? bus.id_rd_addr : bus.id_rt_addr;
   end

   // Next-state: bubble or capture; stall/reset are applied in the register process.
   always_comb begin
      nxt_valid     = bus.ex_valid;
      nxt_pc_plus4  = bus.ex_pc_plus4;
      nxt_rs_data   = bus.ex_rs_data;
      nxt_rt_data   = bus.ex_rt_data;
      nxt_imm       = bus.ex_imm;
      nxt_rs_addr   = bus.ex_rs_addr;
      nxt_rt_addr   = bus.ex_rt_addr;
      nxt_write_reg = bus.ex_write_reg;
      nxt_shamt     = bus.ex_shamt;
      nxt_ctrl      = bus.ex_ctrl;
      nxt_count     = bubble_count;

      if (bubble) begin
         nxt_valid     = 1'b0;
         nxt_pc_plus4  = '0;
         nxt_rs_data   = '0;
         nxt_rt_data   = '0;
         nxt_imm       = '0;
         nxt_rs_addr   = '0;
         nxt_rt_addr   = '0;
         nxt_write_reg = '0;
         nxt_shamt     = '0;
         nxt_ctrl      = '0;
         if (bubble_count != '1) begin
            nxt_count = bubble_count + CNT_W'(1);
         end
      end else begin
         nxt_valid     = bus.id_valid;
         nxt_pc_plus4  = bus.id_pc_plus4;
         nxt_rs_data   = bus.id_rs_data;
         nxt_rt_data   = bus.id_rt_data;
         nxt_imm       = ext_imm;
         nxt_rs_addr   = bus.id_rs_addr;
         nxt_rt_addr   = bus.id_rt_addr;
         nxt_write_reg = dest_reg;
         nxt_shamt     = bus.id_shamt;
         nxt_ctrl      = bus.id_valid ? bus.id_ctrl : '0;
      end
   end

   // State register: reset beats stall, stall freezes everything including the counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.ex_valid     <= 1'b0;
         bus.ex_pc_plus4  <= '0;
         bus.ex_rs_data   <= '0;
         bus.ex_rt_data   <= '0;
         bus.ex_imm       <= '0;
         bus.ex_rs_addr   <= '0;
         bus.ex_rt_addr   <= '0;
         bus.ex_write_reg <= '0;
         bus.ex_shamt     <= '0;
         bus.ex_ctrl      <= '0;
         bubble_count     <= '0;
      end else if (!stall_in) begin
         bus.ex_valid     <= nxt_valid;
         bus.ex_pc_plus4  <= nxt_pc_plus4;
         bus.ex_rs_data   <= nxt_rs_data;
         bus.ex_rt_data   <= nxt_rt_data;
         bus.ex_imm       <= nxt_imm;
         bus.ex_rs_addr   <= nxt_rs_addr;
         bus.ex_rt_addr   <= nxt_rt_addr;
         bus.ex_write_reg <= nxt_write_reg;
         bus.ex_shamt     <= nxt_shamt;
         bus.ex_ctrl      <= nxt_ctrl;
         bubble_count     <= nxt_count;
      end
   end
endmodule

// File: tb/tb_id_ex_stage_register.sv
// Directed bench for id_ex_stage_register: expected EX state is pushed to a
// queue when each step is driven and popped after the capturing edge.
module tb_id_ex_stage_register;
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] imm;
      logic [4:0]  rs_addr;
      logic [4:0]  rt_addr;
      logic [4:0]  wr;
      logic [4:0]  shamt;
      logic [9:0]  ctrl;
      logic [15:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_in;
   logic        flush;
   logic        load_use_stall;
   logic [15:0] bubble_count;

   int   tests = 0;
   int   fails = 0;
   exp_t cur;
   exp_t sb_q[$];

   id_ex_stage_register_if #(.DATA_W(32), .REG_AW(5)) bus ();

   id_ex_stage_register #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut (
      .clk            (clk),
      .reset          (reset),
      .stall_in       (stall_in),
      .flush          (flush),
      .bus            (bus),
      .load_use_stall (load_use_stall),
      .bubble_count   (bubble_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t observed();
      exp_t o;
      o.valid   = bus.ex_valid;
      o.pc      = bus.ex_pc_plus4;
      o.rs      = bus.ex_rs_data;
      o.rt      = bus.ex_rt_data;
      o.imm     = bus.ex_imm;
      o.rs_addr = bus.ex_rs_addr;
      o.rt_addr = bus.ex_rt_addr;
      o.wr      = bus.ex_write_reg;
      o.shamt   = bus.ex_shamt;
      o.ctrl    = bus.ex_ctrl;
      o.cnt     = bubble_count;
      return o;
   endfunction

   // Reference behaviour of one rising edge, from the bench's own copy of EX state.
   task automatic step(input string tag);
      exp_t nxt;
      exp_t got;
      exp_t want;
      logic lus;
      #1;
      lus = cur.valid && cur.ctrl[1] && (cur.rt_addr != 5'd0) && bus.id_valid &&
            ((cur.rt_addr == bus.id_rs_addr) || (cur.rt_addr == bus.id_rt_addr));
      check({tag, ".load_use_stall"}, 192'(load_use_stall), 192'(lus));
      nxt = cur;
      if (reset) begin
         nxt = '0;
      end else if (!stall_in) begin
         if (flush || lus) begin
            nxt     = '0;
            nxt.cnt = (cur.cnt == 16'hFFFF) ? cur.cnt : cur.cnt + 16'd1;
         end else begin
            nxt.valid   = bus.id_valid;
            nxt.pc      = bus.id_pc_plus4;
            nxt.rs      = bus.id_rs_data;
            nxt.rt      = bus.id_rt_data;
            nxt.imm     = bus.id_zero_ext ? {16'h0000, bus.id_sign_imm[15:0]} : bus.id_sign_imm;
            nxt.rs_addr = bus.id_rs_addr;
            nxt.rt_addr = bus.id_rt_addr;
            nxt.wr      = bus.id_ctrl[5] ? bus.id_rd_addr : bus.id_rt_addr;
            nxt.shamt   = bus.id_shamt;
            nxt.ctrl    = bus.id_valid ? bus.id_ctrl : 10'd0;
         end
      end
      sb_q.push_back(nxt);
      cur = nxt;
      @(posedge clk);
      #1;
      got = observed();
      if (sb_q.size() == 0) begin
         check({tag, ".queue"}, 192'(0), 192'(1));
      end else begin
         want = sb_q.pop_front();
         check({tag, ".ex_state"}, 192'(got), 192'(want));
      end
   endtask

   task automatic drive_id(input logic v, input logic [31:0] imm, input logic zext,
                           input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [9:0] ctrl);
      bus.id_valid    = v;
      bus.id_pc_plus4 = bus.id_pc_plus4 + 32'd4;
      bus.id_rs_data  = $urandom;
      bus.id_rt_data  = $urandom;
      bus.id_sign_imm = imm;
      bus.id_zero_ext = zext;
      bus.id_rs_addr  = rs;
      bus.id_rt_addr  = rt;
      bus.id_rd_addr  = rd;
      bus.id_shamt    = 5'($urandom_range(0, 31));
      bus.id_ctrl     = ctrl;
   endtask

   initial begin
      cur      = '0;
      reset    = 1'b1;
      stall_in = 1'b0;
      flush    = 1'b0;
      bus.id_pc_plus4 = 32'h0040_0000;
      drive_id(1'b1, 32'h1234_5678, 1'b0, 5'd8, 5'd8, 5'd9, 10'h3FF);
      @(posedge clk);
      #1;

      // Reset with busy inputs.
      step("reset0");
      step("reset1");
      check("reset.ex_valid", 192'(bus.ex_valid), 192'(0));
      check("reset.bubble_count", 192'(bubble_count), 192'(0));
      check("reset.load_use_stall", 192'(load_use_stall), 192'(0));
      reset = 1'b0;

      // Immediate extension.
      drive_id(1'b1, 32'hFFFF_8000, 1'b0, 5'd1, 5'd2, 5'd3, 10'h011);
      step("imm_sext");
      check("imm_sext.value", 192'(bus.ex_imm), 192'(32'hFFFF_8000));
      drive_id(1'b1, 32'hFFFF_8000, 1'b1, 5'd1, 5'd2, 5'd3, 10'h011);
      step("imm_zext");
      check("imm_zext.value", 192'(bus.ex_imm), 192'(32'h0000_8000));
      drive_id(1'b1, 32'h0000_2000, 1'b0, 5'd1, 5'd2, 5'd3, 10'h011);
      step("imm_pos_s");
      check("imm_pos_s.value", 192'(bus.ex_imm), 192'(32'h0000_2000));
      drive_id(1'b1, 32'h0000_2000, 1'b1, 5'd1, 5'd2, 5'd3, 10'h011);
      step("imm_pos_z");
      check("imm_pos_z.value", 192'(bus.ex_imm), 192'(32'h0000_2000));

      // Destination select.
      drive_id(1'b1, 32'h0, 1'b0, 5'd1, 5'd3, 5'd12, 10'h021);
      step("dst_rd");
      check("dst_rd.value", 192'(bus.ex_write_reg), 192'(12));
      drive_id(1'b1, 32'h0, 1'b0, 5'd1, 5'd3, 5'd12, 10'h001);
      step("dst_rt");
      check("dst_rt.value", 192'(bus.ex_write_reg), 192'(3));

      // Invalid ID instruction carries no control.
      drive_id(1'b0, 32'h0, 1'b0, 5'd4, 5'd5, 5'd6, 10'h3FF);
      step("invalid");
      check("invalid.ex_ctrl", 192'(bus.ex_ctrl), 192'(0));

      // Load-use on rt=8, then the add re-presented.
      drive_id(1'b1, 32'h4, 1'b0, 5'd1, 5'd8, 5'd0, 10'h00B);
      step("lw8");
      drive_id(1'b1, 32'h0, 1'b0, 5'd8, 5'd9, 5'd10, 10'h021);
      #1;
      check("lu.stall_high", 192'(load_use_stall), 192'(1));
      step("lu_bubble");
      check("lu_bubble.ex_valid", 192'(bus.ex_valid), 192'(0));
      check("lu_bubble.ex_ctrl", 192'(bus.ex_ctrl), 192'(0));
      check("lu_bubble.count", 192'(bubble_count), 192'(1));
      check("lu.stall_low", 192'(load_use_stall), 192'(0));
      step("lu_add");
      check("lu_add.ex_valid", 192'(bus.ex_valid), 192'(1));
      check("lu_add.write_reg", 192'(bus.ex_write_reg), 192'(10));

      // Load to $zero never stalls.
      drive_id(1'b1, 32'h4, 1'b0, 5'd1, 5'd0, 5'd0, 10'h00B);
      step("lw0");
      drive_id(1'b1, 32'h0, 1'b0, 5'd0, 5'd9, 5'd10, 10'h021);
      #1;
      check("lw0.no_stall", 192'(load_use_stall), 192'(0));
      step("lw0_add");
      check("lw0_add.count", 192'(bubble_count), 192'(1));

      // Flush held off by stall, taken when stall drops.
      flush    = 1'b1;
      stall_in = 1'b1;
      step("flush_stall");
      check("flush_stall.valid", 192'(bus.ex_valid), 192'(1));
      check("flush_stall.count", 192'(bubble_count), 192'(1));
      stall_in = 1'b0;
      step("flush_go");
      check("flush_go.count", 192'(bubble_count), 192'(2));
      flush = 1'b0;

      // Reset during stall clears state.
      drive_id(1'b1, 32'h77, 1'b0, 5'd2, 5'd3, 5'd4, 10'h021);
      step("pre_rst");
      stall_in = 1'b1;
      reset    = 1'b1;
      step("rst_stall");
      check("rst_stall.count", 192'(bubble_count), 192'(0));
      reset    = 1'b0;
      stall_in = 1'b0;
      step("post_rst");

      // Saturation of the bubble counter.
      flush = 1'b1;
      for (int i = 0; i < 65535; i++) begin
         step("sat_fill");
      end
      check("sat.full", 192'(bubble_count), 192'(16'hFFFF));
      step("sat_extra");
      check("sat.hold", 192'(bubble_count), 192'(16'hFFFF));
      flush = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
